fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a fetch PC feeding a small instruction queue with redirect flush.
// Optional misaligned-redirect detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        misaligned_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_mem_q [QUEUE_DEPTH];
  logic [31:0]     pc_mem_q    [QUEUE_DEPTH];

  logic        valid, full, pop, fetch_en, fetch_blocked;
  logic [31:0] redirect_target;
  logic        mis_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_d;

  assign redirect_target = redirect_pc_i;
  assign fetch_blocked   = mis_q;

  // Sticky until a redirect lands on an aligned target.
  always_comb begin
    mis_d = mis_q;
    if (redirect_i) mis_d = (redirect_pc_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`else
  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign fetch_blocked   = 1'b0;
  assign mis_q           = 1'b0;
`endif

  assign valid    = (count_q != '0);
  assign full     = (count_q == CntW'(QUEUE_DEPTH));
  assign pop      = valid & instr_ready_i & ~redirect_i;
  assign fetch_en = (~full | pop) & ~redirect_i & ~fetch_blocked;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_en) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (fetch_en && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !fetch_en) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a nonzero count.
  always_ff @(posedge clk_i) begin
    if (fetch_en) begin
      instr_mem_q[wr_ptr_q] <= mem_instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign mem_addr_o    = pc_q;
  assign instr_valid_o = valid;
  assign instr_o       = valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc_o          = valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver models fetch/flush on a queue of PCs,
// monitor compares the DUT queue head and status against it every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] KEY      = 32'h5A5A_00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic        misaligned;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_addr_o   (mem_addr),
    .mem_instr_i  (mem_instr),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .pc_o         (pc),
    .misaligned_o (misaligned)
  );

  always #5 clk = ~clk;

  // Memory model: word is a keyed function of its address.
  assign mem_instr = mem_addr ^ KEY;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] m_pc;
  logic        m_mis;
  int          occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, between the driver's updates.
  initial begin
    forever begin
      @(negedge clk);
      check("mem_addr", mem_addr, m_pc);
      check("valid", 32'(instr_valid), 32'(sb.size() != 0));
      check("misaligned", 32'(misaligned), 32'(m_mis));
      if (instr_valid && sb.size() > 0) begin
        check("head_pc", pc, sb[0]);
        check("head_instr", instr, sb[0] ^ KEY);
        if (instr_ready) void'(sb.pop_front());
      end else if (!instr_valid) begin
        check("empty_pc", pc, 32'h0);
        check("empty_instr", instr, 32'h0);
      end
    end
  end

  // Apply one clock edge to the reference model; occupancy is taken before the edge's pop.
  task automatic model_edge(input logic rdy, input logic redir, input logic [31:0] tgt,
                            input int pre_occ);
    bit do_pop, do_fetch;
    if (redir) begin
      sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      m_mis = (tgt[1:0] != 2'b00);
      m_pc  = tgt;
`else
      m_pc  = tgt & 32'hFFFF_FFFC;
`endif
    end else begin
      do_pop   = (pre_occ > 0) && rdy;
      do_fetch = ((pre_occ < DEPTH) || do_pop) && !m_mis;
      if (do_fetch) begin
        sb.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at posedge+1; drives inputs for the next edge then updates the model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    occ         = sb.size();
    @(posedge clk);
    #1;
    model_edge(rdy, redir, tgt, occ);
    redirect = 1'b0;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_addr", mem_addr, RESET_PC);
    check("async_mis", 32'(misaligned), 32'h0);
    sb.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    m_pc        = RESET_PC;
    m_mis       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with decode always ready.
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Back-pressure, then resume.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Redirect while full.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0100);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    // Back-to-back redirects: last one wins.
    step(1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b1, 32'h0000_0800);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    // Misaligned target, then aligned recovery.
    step(1'b1, 1'b1, 32'h0000_0102);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    // Address wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Reset with two entries queued.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    pulse_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset();
      end else if (r < 10) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        if ($urandom_range(0, 3) == 0) tgt[31:4] = 28'hFFF_FFFF;
        step(1'($urandom_range(0, 1)), 1'b1, tgt);
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'b0, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
